tcdm_to_axi_bridge: RTL and testbench

Single-outstanding protocol converter from a 32-bit TCDM master port to a 32-bit AXI4 master. It is the return direction of the SoC interconnect's AXI-to-TCDM path. One instance sits on each AXI output of the SoC interconnect's AXI crossbar: cluster plug, peripheral bus before the AXI-lite bridge, and accelerator slaves. Every TCDM request becomes exactly one single-beat AXI transaction, and the bridge returns exactly one TCDM response per request.

---
 rtl/tcdm_to_axi_bridge_if.sv | 110 +++++++++++
 rtl/tcdm_to_axi_bridge.sv | 220 ++++++++++++++++++++++
 tb/tb_tcdm_to_axi_bridge.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcdm_to_axi_bridge_if.sv
// -----------------------------------------------------------------------------
// tcdm_to_axi_bridge_if
// Bundles the TCDM slave-side port and the AXI4 master-side port of the
// TCDM-to-AXI bridge. Signal names keep the bridge's _i/_o direction suffixes
// so that they read the same as the bridge port list.
//   modport master : bridge view (accepts TCDM requests, issues AXI traffic)
//   modport slave  : environment view (TCDM initiator plus AXI slave)
// Parameters: AXI_ADDR_WIDTH, AXI_DATA_WIDTH, AXI_ID_WIDTH, AXI_USER_WIDTH.
// -----------------------------------------------------------------------------
interface tcdm_to_axi_bridge_if #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 1,
    parameter int unsigned AXI_USER_WIDTH = 6
);
    // TCDM side
    logic                          tcdm_req_i;
    logic                          tcdm_gnt_o;
    logic [AXI_ADDR_WIDTH-1:0]     tcdm_add_i;
    logic                          tcdm_wen_i;
    logic [AXI_DATA_WIDTH-1:0]     tcdm_wdata_i;
    logic [AXI_DATA_WIDTH/8-1:0]   tcdm_be_i;
    logic                          tcdm_r_valid_o;
    logic [AXI_DATA_WIDTH-1:0]     tcdm_r_rdata_o;
    logic                          tcdm_r_opc_o;
    // AW channel
    logic                          axi_aw_valid_o;
    logic                          axi_aw_ready_i;
    logic [AXI_ADDR_WIDTH-1:0]     axi_aw_addr_o;
    logic [AXI_ID_WIDTH-1:0]       axi_aw_id_o;
    logic [7:0]                    axi_aw_len_o;
    logic [2:0]                    axi_aw_size_o;
    logic [1:0]                    axi_aw_burst_o;
    logic                          axi_aw_lock_o;
    logic [3:0]                    axi_aw_cache_o;
    logic [2:0]                    axi_aw_prot_o;
    logic [3:0]                    axi_aw_qos_o;
    logic [3:0]                    axi_aw_region_o;
    logic [AXI_USER_WIDTH-1:0]     axi_aw_user_o;
    logic [5:0]                    axi_aw_atop_o;
    // W channel
    logic                          axi_w_valid_o;
    logic                          axi_w_ready_i;
    logic [AXI_DATA_WIDTH-1:0]     axi_w_data_o;
    logic [AXI_DATA_WIDTH/8-1:0]   axi_w_strb_o;
    logic                          axi_w_last_o;
    // B channel
    logic                          axi_b_valid_i;
    logic                          axi_b_ready_o;
    logic [1:0]                    axi_b_resp_i;
    // AR channel
    logic                          axi_ar_valid_o;
    logic                          axi_ar_ready_i;
    logic [AXI_ADDR_WIDTH-1:0]     axi_ar_addr_o;
    logic [AXI_ID_WIDTH-1:0]       axi_ar_id_o;
    logic [7:0]                    axi_ar_len_o;
    logic [2:0]                    axi_ar_size_o;
    logic [1:0]                    axi_ar_burst_o;
    logic                          axi_ar_lock_o;
    logic [3:0]                    axi_ar_cache_o;
    logic [2:0]                    axi_ar_prot_o;
    logic [3:0]                    axi_ar_qos_o;
    logic [3:0]                    axi_ar_region_o;
    logic [AXI_USER_WIDTH-1:0]     axi_ar_user_o;
    // R channel
    logic                          axi_r_valid_i;
    logic                          axi_r_ready_o;
    logic [AXI_DATA_WIDTH-1:0]     axi_r_data_i;
    logic [1:0]                    axi_r_resp_i;

    modport master (
        input  tcdm_req_i, tcdm_add_i, tcdm_wen_i, tcdm_wdata_i, tcdm_be_i,
        output tcdm_gnt_o, tcdm_r_valid_o, tcdm_r_rdata_o, tcdm_r_opc_o,
        output axi_aw_valid_o, axi_aw_addr_o, axi_aw_id_o, axi_aw_len_o,
               axi_aw_size_o, axi_aw_burst_o, axi_aw_lock_o, axi_aw_cache_o,
               axi_aw_prot_o, axi_aw_qos_o, axi_aw_region_o, axi_aw_user_o,
               axi_aw_atop_o,
        input  axi_aw_ready_i,
        output axi_w_valid_o, axi_w_data_o, axi_w_strb_o, axi_w_last_o,
        input  axi_w_ready_i,
        input  axi_b_valid_i, axi_b_resp_i,
        output axi_b_ready_o,
        output axi_ar_valid_o, axi_ar_addr_o, axi_ar_id_o, axi_ar_len_o,
               axi_ar_size_o, axi_ar_burst_o, axi_ar_lock_o, axi_ar_cache_o,
               axi_ar_prot_o, axi_ar_qos_o, axi_ar_region_o, axi_ar_user_o,
        input  axi_ar_ready_i,
        input  axi_r_valid_i, axi_r_data_i, axi_r_resp_i,
        output axi_r_ready_o
    );

    modport slave (
        output tcdm_req_i, tcdm_add_i, tcdm_wen_i, tcdm_wdata_i, tcdm_be_i,
        input  tcdm_gnt_o, tcdm_r_valid_o, tcdm_r_rdata_o, tcdm_r_opc_o,
        input  axi_aw_valid_o, axi_aw_addr_o, axi_aw_id_o, axi_aw_len_o,
               axi_aw_size_o, axi_aw_burst_o, axi_aw_lock_o, axi_aw_cache_o,
               axi_aw_prot_o, axi_aw_qos_o, axi_aw_region_o, axi_aw_user_o,
               axi_aw_atop_o,
        output axi_aw_ready_i,
        input  axi_w_valid_o, axi_w_data_o, axi_w_strb_o, axi_w_last_o,
        output axi_w_ready_i,
        output axi_b_valid_i, axi_b_resp_i,
        input  axi_b_ready_o,
        input  axi_ar_valid_o, axi_ar_addr_o, axi_ar_id_o, axi_ar_len_o,
               axi_ar_size_o, axi_ar_burst_o, axi_ar_lock_o, axi_ar_cache_o,
               axi_ar_prot_o, axi_ar_qos_o, axi_ar_region_o, axi_ar_user_o,
        output axi_ar_ready_i,
        output axi_r_valid_i, axi_r_data_i, axi_r_resp_i,
        input  axi_r_ready_o
    );
endinterface

// File: rtl/tcdm_to_axi_bridge.sv
// -----------------------------------------------------------------------------
// tcdm_to_axi_bridge
// Single-outstanding converter from a 32-bit TCDM request port to a 32-bit
// AXI4 master. Each granted TCDM request becomes one single-beat AXI
// transaction and produces exactly one one-cycle TCDM response.
// Ports:
//   clk_i  : clock (single domain)
//   rst_ni : asynchronous active-low reset
//   bus    : tcdm_to_axi_bridge_if.master (TCDM request/response + AXI4 AW/W/B/AR/R)
// Optional feature macro: TCDM_TO_AXI_ERR_RESP_EN
//   defined   -> tcdm_r_opc_o reflects resp[1] of the accepted B/R beat
//   undefined -> tcdm_r_opc_o is always 0, error responses complete like OKAY
// -----------------------------------------------------------------------------
module tcdm_to_axi_bridge #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 1,
    parameter int unsigned AXI_USER_WIDTH = 6,
    parameter int unsigned AXI_ID_VALUE   = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    tcdm_to_axi_bridge_if.master          bus
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WRITE  = 3'd1;
    localparam logic [2:0] ST_WAIT_B = 3'd2;
    localparam logic [2:0] ST_READ   = 3'd3;
    localparam logic [2:0] ST_WAIT_R = 3'd4;

    logic [2:0]                    state_q,    state_d;
    logic [AXI_ADDR_WIDTH-1:0]     addr_q,     addr_d;
    logic [AXI_DATA_WIDTH-1:0]     wdata_q,    wdata_d;
    logic [AXI_DATA_WIDTH/8-1:0]   be_q,       be_d;
    logic                          aw_valid_q, aw_valid_d;
    logic                          w_valid_q,  w_valid_d;
    logic                          ar_valid_q, ar_valid_d;
    logic                          r_valid_q,  r_valid_d;
    logic [AXI_DATA_WIDTH-1:0]     r_rdata_q,  r_rdata_d;
    logic                          r_opc_q,    r_opc_d;
    logic                          gnt_s;
    logic                          resp_unused_s;

`ifdef TCDM_TO_AXI_ERR_RESP_EN
    // SLVERR (2'b10) and DECERR (2'b11) both set the error flag.
    function automatic logic err_flag(input logic [1:0] resp);
        return (resp == 2'b10) || (resp == 2'b11);
    endfunction
`endif

    // Response codes feed nothing when error reporting is compiled out.
    assign resp_unused_s = ^{bus.axi_b_resp_i, bus.axi_r_resp_i};

    // Next-state and payload capture for the single-outstanding FSM.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        ar_valid_d = ar_valid_q;
        r_valid_d  = 1'b0;
        r_rdata_d  = r_rdata_q;
        r_opc_d    = r_opc_q;
        gnt_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gnt_s = bus.tcdm_req_i;
                if (bus.tcdm_req_i) begin
                    addr_d  = bus.tcdm_add_i;
                    wdata_d = bus.tcdm_wdata_i;
                    be_d    = bus.tcdm_be_i;
                    if (bus.tcdm_wen_i) begin
                        state_d    = ST_READ;
                        ar_valid_d = 1'b1;
                    end else begin
                        state_d    = ST_WRITE;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // AW and W retire independently; a low valid stays low.
                if (bus.axi_aw_ready_i) begin
                    aw_valid_d = 1'b0;
                end else begin
                    aw_valid_d = aw_valid_q;
                end
                if (bus.axi_w_ready_i) begin
                    w_valid_d = 1'b0;
                end else begin
                    w_valid_d = w_valid_q;
                end
                if (!aw_valid_d && !w_valid_d) begin
                    state_d = ST_WAIT_B;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WAIT_B: begin
                if (bus.axi_b_valid_i) begin
                    state_d   = ST_IDLE;
                    r_valid_d = 1'b1;
                    r_rdata_d = {AXI_DATA_WIDTH{1'b0}};
`ifdef TCDM_TO_AXI_ERR_RESP_EN
                    r_opc_d   = err_flag(bus.axi_b_resp_i);
`else
                    r_opc_d   = 1'b0;
`endif
                end else begin
                    state_d = ST_WAIT_B;
                end
            end
            ST_READ: begin
                if (bus.axi_ar_ready_i) begin
                    ar_valid_d = 1'b0;
                    state_d    = ST_WAIT_R;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_WAIT_R: begin
                if (bus.axi_r_valid_i) begin
                    state_d   = ST_IDLE;
                    r_valid_d = 1'b1;
                    r_rdata_d = bus.axi_r_data_i;
`ifdef TCDM_TO_AXI_ERR_RESP_EN
                    r_opc_d   = err_flag(bus.axi_r_resp_i);
`else
                    r_opc_d   = 1'b0;
`endif
                end else begin
                    state_d = ST_WAIT_R;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                aw_valid_d = 1'b0;
                w_valid_d  = 1'b0;
                ar_valid_d = 1'b0;
            end
        endcase
    end

    // State, payload and response registers; reset abandons any transaction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            addr_q     <= {AXI_ADDR_WIDTH{1'b0}};
            wdata_q    <= {AXI_DATA_WIDTH{1'b0}};
            be_q       <= {(AXI_DATA_WIDTH/8){1'b0}};
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_rdata_q  <= {AXI_DATA_WIDTH{1'b0}};
            r_opc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            ar_valid_q <= ar_valid_d;
            r_valid_q  <= r_valid_d;
            r_rdata_q  <= r_rdata_d;
            r_opc_q    <= r_opc_d;
        end
    end

    // Grant is combinational from req in IDLE, suppressed while reset is held.
    assign bus.tcdm_gnt_o     = gnt_s & rst_ni;
    assign bus.tcdm_r_valid_o = r_valid_q;
    assign bus.tcdm_r_rdata_o = r_rdata_q;
    assign bus.tcdm_r_opc_o   = r_opc_q;

    assign bus.axi_aw_valid_o  = aw_valid_q;
    assign bus.axi_aw_addr_o   = addr_q;
    assign bus.axi_aw_id_o     = AXI_ID_WIDTH'(AXI_ID_VALUE);
    assign bus.axi_aw_len_o    = 8'd0;
    assign bus.axi_aw_size_o   = 3'b010;
    assign bus.axi_aw_burst_o  = 2'b01;
    assign bus.axi_aw_lock_o   = 1'b0;
    assign bus.axi_aw_cache_o  = 4'd0;
    assign bus.axi_aw_prot_o   = 3'd0;
    assign bus.axi_aw_qos_o    = 4'd0;
    assign bus.axi_aw_region_o = 4'd0;
    assign bus.axi_aw_user_o   = {AXI_USER_WIDTH{1'b0}};
    assign bus.axi_aw_atop_o   = 6'd0;

    assign bus.axi_w_valid_o   = w_valid_q;
    assign bus.axi_w_data_o    = wdata_q;
    assign bus.axi_w_strb_o    = be_q;
    assign bus.axi_w_last_o    = 1'b1;

    // Response readies are pure decodes of the registered state, so stray beats
    // outside the waiting states are never consumed.
    assign bus.axi_b_ready_o   = (state_q == ST_WAIT_B);
    assign bus.axi_r_ready_o   = (state_q == ST_WAIT_R);

    assign bus.axi_ar_valid_o  = ar_valid_q;
    assign bus.axi_ar_addr_o   = addr_q;
    assign bus.axi_ar_id_o     = AXI_ID_WIDTH'(AXI_ID_VALUE);
    assign bus.axi_ar_len_o    = 8'd0;
    assign bus.axi_ar_size_o   = 3'b010;
    assign bus.axi_ar_burst_o  = 2'b01;
    assign bus.axi_ar_lock_o   = 1'b0;
    assign bus.axi_ar_cache_o  = 4'd0;
    assign bus.axi_ar_prot_o   = 3'd0;
    assign bus.axi_ar_qos_o    = 4'd0;
    assign bus.axi_ar_region_o = 4'd0;
    assign bus.axi_ar_user_o   = {AXI_USER_WIDTH{1'b0}};

endmodule

// File: tb/tb_tcdm_to_axi_bridge.sv
// -----------------------------------------------------------------------------
// tb_tcdm_to_axi_bridge
// Directed bench for tcdm_to_axi_bridge. A reactive AXI slave lives in the
// step() task; expected TCDM responses are queued at grant time and compared
// when tcdm_r_valid_o pulses. Honors TCDM_TO_AXI_ERR_RESP_EN for the opc flag.
// -----------------------------------------------------------------------------
module tb_tcdm_to_axi_bridge;

`ifdef TCDM_TO_AXI_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;

    tcdm_to_axi_bridge_if #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(1), .AXI_USER_WIDTH(6)
    ) bus ();

    tcdm_to_axi_bridge #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(1),
        .AXI_USER_WIDTH(6), .AXI_ID_VALUE(0)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [32:0] exp_q[$];
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_be;
    int n_grant = 0, grant_cyc = 0, n_rsp = 0, last_rsp_cyc = 0;
    int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0;
    int aw_hs_cyc = 0, w_hs_cyc = 0, b_hs_cyc = 0;
    int aw_stall = 0, aw_wait = 0;
    bit aw_done = 1'b0, w_done = 1'b0, b_pend = 1'b0, r_pend = 1'b0, r_hold = 1'b0;
    logic [1:0]  b_resp_v = 2'b00, r_resp_v = 2'b00;
    logic [31:0] r_data_pend = 32'd0;

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        if (a == 32'h1A10_0004) return 32'hDEAD_BEEF;
        else return a ^ 32'hC0FF_EE00;
    endfunction

    function automatic logic exp_opc(input logic [1:0] r);
        return ERR_EN ? r[1] : 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: entered at posedge+1, returns at next posedge+1.
    task automatic step();
        logic [32:0] e;
        #1;
        if (bus.tcdm_r_valid_o === 1'b1) begin
            n_rsp++;
            last_rsp_cyc = cyc;
            chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rsp_rdata", bus.tcdm_r_rdata_o, e[31:0]);
                chk("rsp_opc", 32'(bus.tcdm_r_opc_o), 32'(e[32]));
            end
        end
        if (bus.tcdm_req_i === 1'b1 && bus.tcdm_gnt_o === 1'b1) begin
            n_grant++;
            grant_cyc = cyc;
            cur_addr  = bus.tcdm_add_i;
            cur_wdata = bus.tcdm_wdata_i;
            cur_be    = bus.tcdm_be_i;
            aw_wait   = 0;
            aw_done   = 1'b0;
            w_done    = 1'b0;
            if (bus.tcdm_wen_i) exp_q.push_back({exp_opc(r_resp_v), rdata_of(bus.tcdm_add_i)});
            else                exp_q.push_back({exp_opc(b_resp_v), 32'd0});
        end
        bus.axi_aw_ready_i = (aw_wait >= aw_stall);
        bus.axi_w_ready_i  = 1'b1;
        bus.axi_ar_ready_i = 1'b1;
        bus.axi_b_valid_i  = b_pend;
        bus.axi_b_resp_i   = b_resp_v;
        bus.axi_r_valid_i  = r_pend;
        bus.axi_r_data_i   = r_data_pend;
        bus.axi_r_resp_i   = r_resp_v;
        #1;
        if (bus.axi_b_valid_i && bus.axi_b_ready_o) begin
            n_b++; b_hs_cyc = cyc; b_pend = 1'b0;
        end
        if (bus.axi_r_valid_i && bus.axi_r_ready_o) r_pend = 1'b0;
        if (bus.axi_aw_valid_o && bus.axi_aw_ready_i) begin
            n_aw++; aw_hs_cyc = cyc; aw_done = 1'b1;
            chk("aw_addr", bus.axi_aw_addr_o, cur_addr);
            chk("aw_fmt", 32'({bus.axi_aw_len_o, bus.axi_aw_size_o, bus.axi_aw_burst_o, bus.axi_aw_id_o}),
                32'({8'd0, 3'b010, 2'b01, 1'b0}));
            chk("aw_zero", 32'({bus.axi_aw_lock_o, bus.axi_aw_cache_o, bus.axi_aw_prot_o, bus.axi_aw_qos_o,
                                bus.axi_aw_region_o, bus.axi_aw_user_o, bus.axi_aw_atop_o}), 32'd0);
        end else if (bus.axi_aw_valid_o) begin
            aw_wait++;
        end
        if (bus.axi_w_valid_o && bus.axi_w_ready_i) begin
            n_w++; w_hs_cyc = cyc; w_done = 1'b1;
            chk("w_data", bus.axi_w_data_o, cur_wdata);
            chk("w_strb_last", 32'({bus.axi_w_strb_o, bus.axi_w_last_o}), 32'({cur_be, 1'b1}));
        end
        if (bus.axi_ar_valid_o && bus.axi_ar_ready_i) begin
            n_ar++;
            chk("ar_addr", bus.axi_ar_addr_o, cur_addr);
            chk("ar_fmt", 32'({bus.axi_ar_len_o, bus.axi_ar_size_o, bus.axi_ar_burst_o, bus.axi_ar_id_o}),
                32'({8'd0, 3'b010, 2'b01, 1'b0}));
            chk("ar_zero", 32'({bus.axi_ar_lock_o, bus.axi_ar_cache_o, bus.axi_ar_prot_o, bus.axi_ar_qos_o,
                                bus.axi_ar_region_o, bus.axi_ar_user_o}), 32'd0);
            r_data_pend = rdata_of(bus.axi_ar_addr_o);
            r_pend = !r_hold;
        end
        if (aw_done && w_done) begin
            b_pend = 1'b1; aw_done = 1'b0; w_done = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
        int g0;
        g0 = n_grant;
        bus.tcdm_req_i   = 1'b1;
        bus.tcdm_wen_i   = wen;
        bus.tcdm_add_i   = addr;
        bus.tcdm_wdata_i = wdata;
        bus.tcdm_be_i    = be;
        step();
        bus.tcdm_req_i   = 1'b0;
        chk("gnt_taken", 32'(n_grant - g0), 32'd1);
    endtask

    task automatic wait_rsp(input string tag);
        int start;
        start = n_rsp;
        for (int i = 0; i < 40; i++) begin
            if (n_rsp != start) break;
            step();
        end
        chk({tag, "_rsp_seen"}, 32'(n_rsp - start), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g0, r0;
        int gc[3];
        rst_n = 1'b0;
        bus.tcdm_req_i = 1'b1; bus.tcdm_add_i = 32'd0; bus.tcdm_wen_i = 1'b1;
        bus.tcdm_wdata_i = 32'd0; bus.tcdm_be_i = 4'd0;
        bus.axi_aw_ready_i = 1'b0; bus.axi_w_ready_i = 1'b0; bus.axi_ar_ready_i = 1'b0;
        bus.axi_b_valid_i = 1'b0; bus.axi_b_resp_i = 2'b00;
        bus.axi_r_valid_i = 1'b0; bus.axi_r_data_i = 32'd0; bus.axi_r_resp_i = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        // Reset state with req held high
        chk("rst_gnt", 32'(bus.tcdm_gnt_o), 32'd0);
        chk("rst_axi_hs", 32'({bus.axi_aw_valid_o, bus.axi_w_valid_o, bus.axi_ar_valid_o,
                               bus.axi_b_ready_o, bus.axi_r_ready_o}), 32'd0);
        chk("rst_rsp", 32'({bus.tcdm_r_valid_o, bus.tcdm_r_opc_o}), 32'd0);
        chk("rst_rdata", bus.tcdm_r_rdata_o, 32'd0);
        bus.tcdm_req_i = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Zero-wait read
        issue(1'b1, 32'h1A10_0004, 32'd0, 4'hF);
        wait_rsp("rd1");
        chk("rd1_latency", 32'(last_rsp_cyc - grant_cyc), 32'd3);
        chk("rd1_ar_count", 32'(n_ar), 32'd1);

        // Write with AW stalled 4 cycles, W ready immediately
        aw_stall = 4;
        issue(1'b0, 32'h1A10_0010, 32'h1234_5678, 4'b0110);
        wait_rsp("wr1");
        aw_stall = 0;
        chk("wr1_w_cycle", 32'(w_hs_cyc - grant_cyc), 32'd1);
        chk("wr1_aw_cycle", 32'(aw_hs_cyc - grant_cyc), 32'd5);
        chk("wr1_b_after_aw", 32'(b_hs_cyc - aw_hs_cyc), 32'd1);
        chk("wr1_rsp_after_b", 32'(last_rsp_cyc - b_hs_cyc), 32'd1);
        chk("wr1_counts", 32'({n_aw[7:0], n_w[7:0], n_b[7:0]}), 32'h00_01_01_01);

        // Zero-wait write
        issue(1'b0, 32'h0000_0100, 32'hA5A5_A5A5, 4'hF);
        wait_rsp("wr2");
        chk("wr2_latency", 32'(last_rsp_cyc - grant_cyc), 32'd3);

        // Back-to-back reads with req held high
        g0 = n_grant; r0 = n_rsp;
        bus.tcdm_req_i = 1'b1; bus.tcdm_wen_i = 1'b1; bus.tcdm_add_i = 32'h2000_0000;
        for (int i = 0; i < 40; i++) begin
            if (n_rsp - r0 >= 3) break;
            step();
            if (n_grant - g0 > 0 && n_grant - g0 <= 3 && grant_cyc == cyc - 1) begin
                gc[n_grant - g0 - 1] = grant_cyc;
                if (n_grant - g0 == 3) bus.tcdm_req_i = 1'b0;
                else bus.tcdm_add_i = bus.tcdm_add_i + 32'h0000_0040;
            end
        end
        bus.tcdm_req_i = 1'b0;
        chk("b2b_grants", 32'(n_grant - g0), 32'd3);
        chk("b2b_rsps", 32'(n_rsp - r0), 32'd3);
        chk("b2b_gap01", 32'(gc[1] - gc[0]), 32'd3);
        chk("b2b_gap12", 32'(gc[2] - gc[1]), 32'd3);

        // Error responses on B and R
        b_resp_v = 2'b10;
        issue(1'b0, 32'h4000_0000, 32'h0BAD_F00D, 4'b1001);
        wait_rsp("werr");
        b_resp_v = 2'b00;
        r_resp_v = 2'b11;
        issue(1'b1, 32'h4000_0004, 32'd0, 4'hF);
        wait_rsp("rerr");
        r_resp_v = 2'b00;
        issue(1'b1, 32'h4000_0008, 32'd0, 4'hF);
        wait_rsp("after_err");
        chk("after_err_latency", 32'(last_rsp_cyc - grant_cyc), 32'd3);

        // Stray B/R beats in IDLE must not be consumed
        bus.axi_r_valid_i = 1'b1; bus.axi_r_data_i = 32'hFFFF_FFFF;
        bus.axi_b_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stray_ready", 32'({bus.axi_r_ready_o, bus.axi_b_ready_o}), 32'd0);
            chk("stray_rsp", 32'(bus.tcdm_r_valid_o), 32'd0);
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.axi_r_valid_i = 1'b0; bus.axi_b_valid_i = 1'b0;

        // Reset pulse while waiting for R
        r_hold = 1'b1;
        issue(1'b1, 32'h3000_0008, 32'd0, 4'hF);
        for (int i = 0; i < 10; i++) begin
            if (bus.axi_r_ready_o === 1'b1) break;
            step();
        end
        chk("waitr_reached", 32'(bus.axi_r_ready_o), 32'd1);
        #1;
        bus.tcdm_req_i = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("arst_axi_hs", 32'({bus.axi_aw_valid_o, bus.axi_w_valid_o, bus.axi_ar_valid_o,
                                bus.axi_b_ready_o, bus.axi_r_ready_o}), 32'd0);
        chk("arst_tcdm", 32'({bus.tcdm_gnt_o, bus.tcdm_r_valid_o, bus.tcdm_r_opc_o}), 32'd0);
        exp_q.delete();
        r_hold = 1'b0; r_pend = 1'b0; b_pend = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        bus.tcdm_req_i = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        issue(1'b1, 32'h1A10_0004, 32'd0, 4'hF);
        wait_rsp("post_rst");
        chk("post_rst_latency", 32'(last_rsp_cyc - grant_cyc), 32'd3);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
